// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: default 640x480@60 timing, derived totals, lock FSM states
// and the CRC-16-CCITT constants shared by the capture block and its CRC step.
package vga_capture_pkg;

    // Default timing in pixels / lines
    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_FP_DEF        = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_BP_DEF        = 48;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FP_DEF        = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_BP_DEF        = 33;
    localparam int LOCK_FRAMES_DEF = 2;

    // Derived totals; counters are zeroed on the hsync/vsync falling edge,
    // so the first active pixel sits after sync + back porch.
    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_START_DEF = H_SYNC_DEF + H_BP_DEF;
    localparam int V_START_DEF = V_SYNC_DEF + V_BP_DEF;

    // Stream qualification states
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // CRC-16-CCITT
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: one combinational CRC-16-CCITT step over a 12-bit pixel,
// bits consumed MSB first.
module vga_crc16
    import vga_capture_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [11:0] data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Twelve serial shifts unrolled into one combinational step
    always_comb begin
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/vga_capture.sv
// vga_capture: recovers (x, y, rgb) from a VGA hsync/vsync/RGB stream,
// qualifies it with a SEARCH/ALIGN/LOCKED state machine and, when the
// VGA_CAPTURE_CRC_EN macro is defined, computes a CRC-16 over each frame.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LO   = 10'(H_START);
    localparam logic [9:0] H_HI   = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0] V_LO   = 10'(V_START);
    localparam logic [9:0] V_HI   = 10'(V_START + V_ACTIVE - 1);
    localparam logic [2:0] GOOD_TARGET = 3'(LOCK_FRAMES);

    // Timing recovery state
    logic       hs_prev_q, vs_prev_q;
    logic       vsync_pend_q, vsync_pend_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    // Per-sample decode
    logic hs_edge, vs_edge, boundary;
    logic line_err, frame_err, any_err;
    logic active, pix_fire, first_px, last_px;

    // Lock FSM and registered outputs
    state_e      state_q;
    logic [2:0]  good_q;
    logic        locked_q, err_q;
    logic        pix_valid_q, frame_start_q;
    logic [9:0]  pix_x_q;
    logic [8:0]  pix_y_q;
    logic [11:0] pix_rgb_q;

    // Edge detection, next counter values and error/active decode.
    // Everything here describes the current sample; it only takes effect
    // when pix_en qualifies it.
    always_comb begin
        hs_edge      = ~hsync_in & hs_prev_q;
        vs_edge      = ~vsync_in & vs_prev_q;
        // A vsync edge arms the frame boundary; it lands on the next (or
        // coincident) hsync edge so lines stay whole.
        boundary     = hs_edge & (vsync_pend_q | vs_edge);
        vsync_pend_d = boundary ? 1'b0 : (vsync_pend_q | vs_edge);
        h_d          = hs_edge ? 10'd0 : h_q + 10'd1;
        if (boundary) begin
            v_d = 10'd0;
        end else if (hs_edge) begin
            v_d = v_q + 10'd1;
        end else begin
            v_d = v_q;
        end
        line_err  = hs_edge & (h_q != H_LAST);
        frame_err = boundary & (v_q != V_LAST);
        any_err   = line_err | frame_err;
        active    = (h_d >= H_LO) && (h_d <= H_HI) && (v_d >= V_LO) && (v_d <= V_HI);
        // Active pixels never coincide with an hsync edge, so gating on the
        // current state is equivalent to gating on the post-sample state.
        pix_fire  = pix_en & active & (state_q == ST_LOCKED);
        first_px  = (h_d == H_LO) && (v_d == V_LO);
        last_px   = (h_d == H_HI) && (v_d == V_HI);
    end

    // Horizontal/vertical counters and sync history; frozen while pix_en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            vsync_pend_q <= 1'b0;
            h_q          <= 10'd0;
            v_q          <= 10'd0;
        end else if (pix_en) begin
            hs_prev_q    <= hsync_in;
            vs_prev_q    <= vsync_in;
            vsync_pend_q <= vsync_pend_d;
            h_q          <= h_d;
            v_q          <= v_d;
        end
    end

    // Lock state machine with registered locked/err outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            good_q   <= 3'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (pix_en) begin
                err_q <= any_err & (state_q != ST_SEARCH);
                case (state_q)
                    ST_SEARCH: begin
                        if (boundary) begin
                            state_q <= ST_ALIGN;
                            good_q  <= 3'd0;
                        end
                    end
                    ST_ALIGN: begin
                        // An error on a boundary sample wins: the frame is not counted
                        if (any_err) begin
                            state_q <= ST_SEARCH;
                        end else if (boundary) begin
                            good_q <= good_q + 3'd1;
                            if (good_q + 3'd1 == GOOD_TARGET) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (any_err) begin
                            state_q  <= ST_SEARCH;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Recovered pixel outputs; coordinates/colour hold between valid pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 9'd0;
            pix_rgb_q     <= 12'd0;
        end else begin
            pix_valid_q   <= pix_fire;
            frame_start_q <= pix_fire & first_px;
            if (pix_fire) begin
                pix_x_q   <= h_d - H_LO;
                pix_y_q   <= 9'(v_d - V_LO);
                pix_rgb_q <= rgb_in;
            end
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_base, crc_next, frame_crc_q;
    logic        last_q, crc_valid_q;

    // Restart from the seed on pixel (0,0) so a frame never inherits history
    assign crc_base = first_px ? CRC_SEED : crc_q;

    vga_crc16 u_crc (
        .crc_in  (crc_base),
        .data    (rgb_in),
        .crc_out (crc_next)
    );

    // Running CRC over valid pixels; published the clk after the last pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q       <= 16'd0;
            last_q      <= 1'b0;
            frame_crc_q <= 16'd0;
            crc_valid_q <= 1'b0;
        end else begin
            last_q      <= pix_fire & last_px;
            crc_valid_q <= last_q;
            if (pix_fire) begin
                crc_q <= crc_next;
            end
            if (last_q) begin
                frame_crc_q <= crc_q;
            end
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`else
    assign frame_crc = 16'd0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench for vga_capture on a reduced raster.
module tb_vga_capture;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int LF = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] rgb_in = 12'd0;
    logic        pix_valid, frame_start, locked, err, crc_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_crc;

    always #10 clk = ~clk;

    vga_capture #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .err(err),
        .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
        logic        fs;
    } pix_t;

    pix_t sb_q[$];
    pix_t mon_exp;
    int   n_checks = 0, n_fail = 0;
    int   gen_h = 0, gen_v = 0;
    bit   gen_bnd = 0, sb_arm = 0, rgb_zero = 0, short_req = 0;
    int   valid_cnt = 0, err_cnt = 0, crc_cnt = 0;
    logic [15:0] crc_seen = 16'd0;
    bit   last_prev = 0, crc_nz = 0;

    // Output monitor: scoreboard pops on every recovered pixel
    always @(negedge clk) begin
        if (pix_valid) begin
            valid_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL pix_unexpected: got pix_valid at (%0d,%0d), expected none", pix_x, pix_y);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({pix_x, pix_y, pix_rgb, frame_start} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pix_data: got x=%0d y=%0d rgb=%h fs=%b, expected x=%0d y=%0d rgb=%h fs=%b",
                             pix_x, pix_y, pix_rgb, frame_start, mon_exp.x, mon_exp.y, mon_exp.rgb, mon_exp.fs);
                end
            end
        end else if (frame_start) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_start_alone: got frame_start=1 with pix_valid=0, expected 0");
        end
        if (err) err_cnt++;
        if (crc_valid) begin
            crc_cnt++;
            crc_seen = frame_crc;
            n_checks++;
            if (!last_prev) begin
                n_fail++;
                $display("FAIL crc_timing: got crc_valid not one clk after pixel (%0d,%0d)", HA-1, VA-1);
            end
        end
        if (crc_valid || frame_crc !== 16'd0) crc_nz = 1;
        last_prev = pix_valid && (pix_x == 10'(HA-1)) && (pix_y == 9'(VA-1));
    end

    // Timing generator: one pixel per two clks; pushes expectations when armed
    task automatic gen_pixel();
        bit   act;
        pix_t e;
        act   = gen_h >= HST && gen_h < HST + HA && gen_v >= VST && gen_v < VST + VA;
        e.x   = 10'(gen_h - HST);
        e.y   = 9'(gen_v - VST);
        e.rgb = rgb_zero ? 12'h000 : {e.x[3:0], e.y[3:0], 4'hA};
        e.fs  = (gen_h == HST) && (gen_v == VST);
        gen_bnd = (gen_h == 0) && (gen_v == 0);
        if (act && sb_arm) sb_q.push_back(e);
        @(negedge clk);
        pix_en   = 1'b1;
        hsync_in = (gen_h >= HS);
        vsync_in = (gen_v >= VS);
        rgb_in   = act ? e.rgb : 12'h5C3;
        @(negedge clk);
        pix_en = 1'b0;
        if ((short_req && gen_h == HT - 2) || gen_h == HT - 1) begin
            if (short_req) begin
                short_req = 0;
                sb_arm    = 0;
            end
            gen_h = 0;
            gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
        end else begin
            gen_h++;
        end
    endtask

    task automatic to_boundary();
        do gen_pixel(); while (!gen_bnd);
    endtask

    task automatic run_to(input int h, input int v);
        while (!(gen_h == h && gen_v == v)) gen_pixel();
    endtask

    task automatic check_locked(input string name, input logic exp);
        n_checks++;
        if (locked !== exp) begin
            n_fail++;
            $display("FAIL %s: got locked=%b, expected %b", name, locked, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_crc, crc_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d rgb=%h fs=%b lk=%b err=%b crc=%h cv=%b, expected all 0",
                     pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_crc, crc_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int v0;
        v0 = 0;
        for (int b = 1; b <= 4; b++) begin
            to_boundary();
            check_locked($sformatf("nominal_lock_b%0d", b), (b >= 3));
            if (b == 3) begin
                v0 = valid_cnt;
                sb_arm = 1;
            end
        end
        n_checks++;
        if (valid_cnt - v0 !== HA * VA) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d pixels, expected %0d", valid_cnt - v0, HA * VA);
        end
        n_checks++;
        if (err_cnt !== 0 || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL nominal_clean: got err=%0d pending=%0d, expected 0 and 0", err_cnt, sb_q.size());
        end
    endtask

    task automatic test_short_line();
        bit got;
        int e0, v0;
        got = 0;
        e0  = err_cnt;
        run_to(0, VST + 2);
        short_req = 1;
        for (int i = 0; i < 2 * HT && !got; i++) begin
            gen_pixel();
            if (err) got = 1;
        end
        n_checks++;
        if (!got || gen_h != 1 || gen_v != VST + 3) begin
            n_fail++;
            $display("FAIL short_err: got err_seen=%b at h=%0d v=%0d, expected 1 at h=1 v=%0d", got, gen_h, gen_v, VST + 3);
        end
        check_locked("short_drop", 1'b0);
        for (int b = 1; b <= 3; b++) begin
            to_boundary();
            check_locked($sformatf("short_relock_b%0d", b), (b == 3));
        end
        sb_arm = 1;
        v0 = valid_cnt;
        to_boundary();
        n_checks++;
        if (valid_cnt - v0 !== HA * VA || err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL short_after: got pixels=%0d errs=%0d, expected %0d and 1", valid_cnt - v0, err_cnt - e0, HA * VA);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        run_to(HST + HA / 2, VST + VA / 2);
        gen_pixel();
        n_checks++;
        if (pix_x !== 10'(HA / 2) || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got x=%0d locked=%b, expected %0d and 1", pix_x, locked, HA / 2);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_crc, crc_valid} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got valid=%b x=%0d y=%0d rgb=%h lk=%b crc=%h, expected all 0",
                     pix_valid, pix_x, pix_y, pix_rgb, locked, frame_crc);
        end
        sb_arm = 0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        v0 = valid_cnt;
        for (int b = 1; b <= 3; b++) begin
            to_boundary();
            check_locked($sformatf("rmid_relock_b%0d", b), (b == 3));
        end
        n_checks++;
        if (valid_cnt !== v0) begin
            n_fail++;
            $display("FAIL rmid_novalid: got %0d pixels before relock, expected 0", valid_cnt - v0);
        end
        sb_arm = 1;
        v0 = valid_cnt;
        to_boundary();
        n_checks++;
        if (valid_cnt - v0 !== HA * VA) begin
            n_fail++;
            $display("FAIL rmid_frame: got %0d pixels, expected %0d", valid_cnt - v0, HA * VA);
        end
    endtask

    task automatic test_pix_en_gap();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        run_to(HST + 5, VST + 1);
        repeat (100) @(negedge clk);
        to_boundary();
        n_checks++;
        if (valid_cnt - v0 !== HA * VA || err_cnt !== e0 || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL gap: got pixels=%0d errs=%0d pending=%0d, expected %0d, 0, 0",
                     valid_cnt - v0, err_cnt - e0, sb_q.size(), HA * VA);
        end
        check_locked("gap_locked", 1'b1);
    endtask

`ifdef VGA_CAPTURE_CRC_EN
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [11:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 11; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    task automatic test_crc();
        int c0;
`ifdef VGA_CAPTURE_CRC_EN
        logic [15:0] exp_crc;
        exp_crc = 16'hFFFF;
        for (int i = 0; i < HA * VA; i++) exp_crc = crc_model(exp_crc, 12'h000);
`endif
        c0 = crc_cnt;
        rgb_zero = 1;
        to_boundary();
        rgb_zero = 0;
`ifdef VGA_CAPTURE_CRC_EN
        n_checks++;
        if (crc_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL crc_pulses: got %0d crc_valid pulses, expected 1", crc_cnt - c0);
        end
        n_checks++;
        if (crc_seen !== exp_crc) begin
            n_fail++;
            $display("FAIL crc_value: got %h, expected %h", crc_seen, exp_crc);
        end
`else
        n_checks++;
        if (crc_cnt !== 0 || crc_nz !== 1'b0 || c0 !== 0) begin
            n_fail++;
            $display("FAIL crc_disabled: got pulses=%0d nonzero_seen=%b, expected 0 and 0", crc_cnt, crc_nz);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_reset_mid();
        test_pix_en_gap();
        test_crc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: got no completion by 1000000 ns, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
